// File: rtl/bsg_counter_underflow_set_en.sv
// bsg_counter_underflow_set_en
//
// Loadable down-counter. It counts a programmed interval down to zero under
// an enable, flags zero combinationally and emits a registered expire pulse.
// After that it either reloads the programmed value (periodic mode) or stops
// (one-shot mode). Typical uses are interval timers, watchdogs and
// credit/timeout sequencing.
//
// Optional feature macro: BSG_COUNTER_UNDERFLOW_SET_EN_STICKY_EN
//   When it is defined, the block adds a sticky expired flag (expired_o).
//   The flag is cleared by clear_i.
//
// Ports
//   clk_i      in   clock, all state changes on its rising edge
//   reset_i    in   synchronous active-high reset
//   set_i      in   load val_i into count and reload registers and arm the counter
//   val_i      in   load value (width_p bits)
//   en_i       in   advance enable, ignored while set_i is high
//   oneshot_i  in   1 = stop at zero, 0 = reload at zero (sampled at zero-advance)
//   count_o    out  current count (registered)
//   zero_o     out  combinational count_o == 0
//   running_o  out  armed flag (registered)
//   expire_o   out  single-cycle expire pulse (registered)
//   clear_i    in   clears expired_o (macro only)
//   expired_o  out  sticky expire flag (macro only)

module bsg_counter_underflow_set_en #(
   parameter int unsigned width_p = 24
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               set_i,
   input  logic [width_p-1:0] val_i,
   input  logic               en_i,
   input  logic               oneshot_i,
`ifdef BSG_COUNTER_UNDERFLOW_SET_EN_STICKY_EN
   input  logic               clear_i,
   output logic               expired_o,
`endif
   output logic [width_p-1:0] count_o,
   output logic               zero_o,
   output logic               running_o,
   output logic               expire_o
);

   localparam int unsigned cnt_w_lp = width_p;

   typedef enum logic [0:0] {
      STOPPED = 1'b0,
      ARMED   = 1'b1
   } state_e;

   state_e              state_r, state_n;
   logic [cnt_w_lp-1:0] count_r, count_n;
   logic [cnt_w_lp-1:0] reload_r, reload_n;
   logic                expire_r, expire_n;
   logic                zero_adv;

`ifdef BSG_COUNTER_UNDERFLOW_SET_EN_STICKY_EN
   logic                expired_r, expired_n;
`endif

   // Next-state and datapath: set beats advance, and the zero case never wraps
   always_comb begin
      state_n  = state_r;
      count_n  = count_r;
      reload_n = reload_r;
      expire_n = 1'b0;
      zero_adv = 1'b0;

      if (set_i) begin
         count_n  = val_i;
         reload_n = val_i;
         state_n  = ARMED;
      end else if (en_i && (state_r == ARMED)) begin
         if (count_r != '0) begin
            count_n = count_r - cnt_w_lp'(1);
         end else begin
            zero_adv = 1'b1;
            expire_n = 1'b1;
            if (oneshot_i) begin
               state_n = STOPPED;
            end else begin
               count_n = reload_r;
            end
         end
      end
   end

`ifdef BSG_COUNTER_UNDERFLOW_SET_EN_STICKY_EN
   // Sticky flag: an expire event in the same cycle as clear_i leaves it set
   always_comb begin
      expired_n = expired_r;
      if (zero_adv) begin
         expired_n = 1'b1;
      end else if (clear_i) begin
         expired_n = 1'b0;
      end
   end
`endif

   // State registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r  <= STOPPED;
         count_r  <= '0;
         reload_r <= '0;
         expire_r <= 1'b0;
      end else begin
         state_r  <= state_n;
         count_r  <= count_n;
         reload_r <= reload_n;
         expire_r <= expire_n;
      end
   end

`ifdef BSG_COUNTER_UNDERFLOW_SET_EN_STICKY_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         expired_r <= 1'b0;
      end else begin
         expired_r <= expired_n;
      end
   end

   assign expired_o = expired_r;
`endif

   assign count_o   = count_r;
   assign zero_o    = (count_r == '0);
   assign running_o = (state_r == ARMED);
   assign expire_o  = expire_r;

endmodule

// File: tb/tb_bsg_counter_underflow_set_en.sv
// Directed self-checking bench for bsg_counter_underflow_set_en.
// The sticky-flag section is built only when
// BSG_COUNTER_UNDERFLOW_SET_EN_STICKY_EN is defined.

module tb_bsg_counter_underflow_set_en;

   localparam int unsigned W = 24;

   logic         clk_i = 1'b0;
   logic         reset_i, set_i, en_i, oneshot_i;
   logic [W-1:0] val_i;
   logic [W-1:0] count_o;
   logic         zero_o, running_o, expire_o;
`ifdef BSG_COUNTER_UNDERFLOW_SET_EN_STICKY_EN
   logic         clear_i;
   logic         expired_o;
`endif

   int checks   = 0;
   int failures = 0;

   bsg_counter_underflow_set_en #(.width_p(W)) dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .set_i     (set_i),
      .val_i     (val_i),
      .en_i      (en_i),
      .oneshot_i (oneshot_i),
`ifdef BSG_COUNTER_UNDERFLOW_SET_EN_STICKY_EN
      .clear_i   (clear_i),
      .expired_o (expired_o),
`endif
      .count_o   (count_o),
      .zero_o    (zero_o),
      .running_o (running_o),
      .expire_o  (expire_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int cnt, input bit run, input bit exp_pulse);
      chk({tag, ".count"},   32'(count_o),   32'(cnt));
      chk({tag, ".zero"},    32'(zero_o),    32'(cnt == 0));
      chk({tag, ".running"}, 32'(running_o), 32'(run));
      chk({tag, ".expire"},  32'(expire_o),  32'(exp_pulse));
   endtask

   initial begin
      int exp_cnt [8];
      bit exp_exp [8];

      reset_i = 1'b1; set_i = 1'b0; en_i = 1'b0; oneshot_i = 1'b0; val_i = '0;
`ifdef BSG_COUNTER_UNDERFLOW_SET_EN_STICKY_EN
      clear_i = 1'b0;
`endif
      step();
      step();
      reset_i = 1'b0;
      chk_all("reset", 0, 1'b0, 1'b0);

      // Idle while stopped, even with enable high
      en_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_all("idle_stopped", 0, 1'b0, 1'b0);
      end

      // Periodic with val 3: period 4, pulse coincides with return to 3
      set_i = 1'b1; val_i = W'(3); oneshot_i = 1'b0;
      step();
      set_i = 1'b0;
      chk_all("per_set", 3, 1'b1, 1'b0);
      exp_cnt = '{2, 1, 0, 3, 2, 1, 0, 3};
      exp_exp = '{0, 0, 0, 1, 0, 0, 0, 1};
      for (int i = 0; i < 8; i++) begin
         step();
         chk_all("periodic", exp_cnt[i], 1'b1, exp_exp[i]);
      end

      // One-shot with val 2
      set_i = 1'b1; val_i = W'(2); oneshot_i = 1'b1;
      step();
      set_i = 1'b0;
      chk_all("os_set", 2, 1'b1, 1'b0);
      step(); chk_all("os_1", 1, 1'b1, 1'b0);
      step(); chk_all("os_0", 0, 1'b1, 1'b0);
      step(); chk_all("os_expire", 0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all("os_hold", 0, 1'b0, 1'b0);
      end

      // Restart while running: set wins over enable
      set_i = 1'b1; val_i = W'(5); oneshot_i = 1'b0;
      step();
      set_i = 1'b0;
      chk_all("rs_set5", 5, 1'b1, 1'b0);
      step(); step(); step();
      chk_all("rs_at2", 2, 1'b1, 1'b0);
      set_i = 1'b1; val_i = W'(7);
      step();
      set_i = 1'b0;
      chk_all("rs_set7", 7, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         step();
         chk_all("rs_down", 6 - i, 1'b1, 1'b0);
      end
      step();
      chk_all("rs_reload", 7, 1'b1, 1'b1);

      // Set in the cycle of a zero-advance suppresses the pulse
      set_i = 1'b1; val_i = W'(1);
      step();
      set_i = 1'b0;
      step();
      chk_all("sz_at0", 0, 1'b1, 1'b0);
      set_i = 1'b1; val_i = W'(4);
      step();
      set_i = 1'b0;
      chk_all("sz_set_wins", 4, 1'b1, 1'b0);

      // Reload value 0: pulse after every enabled cycle only
      set_i = 1'b1; val_i = W'(0);
      step();
      set_i = 1'b0;
      chk_all("z_set", 0, 1'b1, 1'b0);
      en_i = 1'b1; step(); chk_all("z_en1", 0, 1'b1, 1'b1);
      en_i = 1'b0; step(); chk_all("z_en0", 0, 1'b1, 1'b0);
      en_i = 1'b1; step(); chk_all("z_en1b", 0, 1'b1, 1'b1);
      en_i = 1'b1; step(); chk_all("z_en1c", 0, 1'b1, 1'b1);

      // Reset mid-count
      set_i = 1'b1; val_i = W'(5);
      step();
      set_i = 1'b0;
      step();
      chk_all("rm_pre", 4, 1'b1, 1'b0);
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      chk_all("rm_reset", 0, 1'b0, 1'b0);

`ifdef BSG_COUNTER_UNDERFLOW_SET_EN_STICKY_EN
      chk("st_reset", 32'(expired_o), 32'd0);
      en_i = 1'b1; oneshot_i = 1'b0;
      set_i = 1'b1; val_i = W'(1);
      step();
      set_i = 1'b0;
      step();
      chk("st_before", 32'(expired_o), 32'd0);
      step();
      chk("st_event", 32'(expired_o), 32'd1);
      chk_all("st_event", 1, 1'b1, 1'b1);
      clear_i = 1'b1;
      step();
      chk("st_clear", 32'(expired_o), 32'd0);
      step();
      chk("st_clear_vs_event", 32'(expired_o), 32'd1);
      clear_i = 1'b0;
      set_i = 1'b1; val_i = W'(6);
      step();
      set_i = 1'b0;
      chk("st_set_keeps", 32'(expired_o), 32'd1);
      step();
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      chk("st_reset_mid", 32'(expired_o), 32'd0);
      chk("st_reset_cnt", 32'(count_o), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bsg_counter_underflow_set_en.md
# bsg_counter_underflow_set_en

Loadable down-counter that counts a programmed value down to zero under an enable. It flags zero combinationally, emits a registered expire pulse, and then either reloads (periodic) or stops (one-shot). It is the counterpart of the loadable overflow up-counter: that block detects a terminal count by counting up, and this one consumes an interval by counting down. Typical uses are interval and watchdog timers and credit/timeout sequencing in bsg-style datapaths.

## Interface
- width_p, default 24: counter and load-value width in bits.
- clk_i  input  1  clock; all state updates on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- set_i  input  1  load `val_i` into the counter and the reload register; arms the counter.
- val_i  input  width_p  load value.
- en_i  input  1  decrement/advance enable; sampled only when `set_i`=0.
- oneshot_i  input  1  mode select, sampled at each zero-advance: 1 = stop at zero, 0 = reload.
- count_o  output  width_p  current count (registered).
- zero_o  output  1  combinational, `count_o == 0`.
- running_o  output  1  registered armed flag.
- expire_o  output  1  registered single-cycle expire pulse.
- expired_o  output  1  sticky expire flag; present only with the macro defined.
- clear_i  input  1  clears `expired_o`; present only with the macro defined.

## Operation
- State:
  - `count_r` (width_p bits)
  - `reload_r` (width_p bits)
  - `running_r` (1 bit)
  - `expire_r` (1 bit)
  - `expired_r` (1 bit, macro only)
- Priority per cycle: `reset_i` > `set_i` > `en_i`.
- Reset: `count_r`=0, `reload_r`=0, `running_r`=0, `expire_r`=0, `expired_r`=0. Resulting outputs: `count_o`=0, `zero_o`=1, `running_o`=0, `expire_o`=0, `expired_o`=0.
- Set (`set_i`=1):
  - `count_r` <= `val_i`, `reload_r` <= `val_i`, `running_r` <= 1, `expire_r` <= 0.
  - `en_i` is ignored in the same cycle.
  - Set is allowed while running (restart) and while stopped.
- Advance (`set_i`=0, `en_i`=1, `running_r`=1):
  - `count_r` != 0: `count_r` <= `count_r` - 1.
  - `count_r` == 0 and `oneshot_i`=0: `count_r` <= `reload_r`, `expire_r` <= 1.
  - `count_r` == 0 and `oneshot_i`=1: `count_r` holds 0, `running_r` <= 0, `expire_r` <= 1.
- Idle (`en_i`=0, or `running_r`=0): all state holds, except `expire_r` <= 0.
- States:
  - STOPPED (`running_r`=0). Transitions: set -> ARMED; reset -> STOPPED.
  - ARMED (`running_r`=1). Transitions: one-shot zero-advance -> STOPPED; reset -> STOPPED.
- Period in periodic mode is `reload_r`+1 enabled cycles. With `reload_r`=0, `expire_o` pulses after every enabled cycle and `zero_o` stays 1.
- Arithmetic: the decrement is modulo 2^width_p but never wraps below 0, because the zero case always takes the reload/stop path.
- `zero_o` reflects `count_r` regardless of `running_r`; after reset it is 1 while STOPPED.

## Timing
- `count_o`, `running_o`, and `expire_o` change only on clock edges; latency from a qualifying input to the new value is 1 cycle.
- `zero_o` is combinational from `count_r` and therefore valid in the same cycle as `count_o`.
- `expire_o` is high for exactly the one cycle following the enabled zero-advance. Back-to-back pulses occur only when `reload_r`=0 and `en_i` is held.
- Set in the cycle of a zero-advance: set wins and `expire_o` stays 0 the next cycle.
- Reset mid-count: the next cycle shows reset values; no expire pulse is emitted.

## Configuration
- Macro: `BSG_COUNTER_UNDERFLOW_SET_EN_STICKY_EN`.
- Defined:
  - Adds `clear_i` and `expired_o`.
  - `expired_r` <= 1 on any zero-advance. Otherwise, `clear_i` causes `expired_r` <= 0.
  - When a zero-advance and `clear_i` occur in the same cycle, `expired_r` ends up 1 (the event wins).
  - Reset clears `expired_r`. Set does not affect it.
- Undefined: neither port exists and there is no sticky state; all other behaviour is identical.

## Test plan
- Reset then idle 5 cycles: `count_o`=0, `zero_o`=1, `running_o`=0, `expire_o`=0 throughout, even with `en_i`=1.
- Set `val_i`=3, periodic, `en_i`=1 continuously:
  - `count_o` runs 3,2,1,0,3,2,...
  - `expire_o` is high exactly in the cycle after each 0 is consumed, i.e. coincident with each return to 3 (period 4).
- Set `val_i`=2, `oneshot_i`=1, `en_i`=1:
  - `count_o` runs 2,1,0, then holds 0.
  - A single `expire_o` pulse; `running_o` falls in the same cycle.
  - Further `en_i` produces no pulses.
- Set `val_i`=5, run to 2, then `set_i`=1 with `val_i`=7 while `en_i`=1: next `count_o`=7 (no decrement), `reload_r`=7; the next expire arrives after 8 enabled cycles.
- Set `val_i`=0, periodic, `en_i` toggled 1,0,1,1: `expire_o` pulses after each enabled cycle only; `count_o` stays 0.
- Macro defined: expire event sets `expired_o`=1. `clear_i` then clears it. `clear_i` coincident with a new expire leaves `expired_o`=1. `reset_i` mid-count gives `count_o`=0 and `expired_o`=0 the next cycle.
